rv32imf_obi_mem_responder: RTL and testbench
============================================

RV32IMF_OBI_MEM_RESPONDER -- requirements
Module: rv32imf_obi_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning memory size in 32-bit words (power of two, >=2).
REQ-002 SHALL have parameter RESP_LATENCY, default 1, meaning cycles from grant to rvalid (legal 1..4).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, meaning maximum granted-but-unanswered transactions (legal 1..4).
REQ-004 clk_i  input  1  sole clock; all logic on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 req_i  input  1  initiator request valid.
REQ-007 gnt_o  output  1  request accepted this cycle.
REQ-008 addr_i  input  32  byte address.
REQ-009 we_i  input  1  1 = write, 0 = read.
REQ-010 be_i  input  4  byte enables, bit n covers wdata_i[8n+7:8n].
REQ-011 wdata_i  input  32  write data.
REQ-012 rvalid_o  output  1  one-cycle response strobe.
REQ-013 rdata_o  output  32  read data, valid only with rvalid_o.
REQ-014 stall_i  input  1  test hook; forces gnt_o low while high.

Function
REQ-015 gnt_o SHALL be combinational: req_i & ~stall_i & (outstanding < MAX_OUTSTANDING).
REQ-016 A transaction SHALL be accepted only in a cycle where req_i and gnt_o are both high; at most one per cycle.
REQ-017 Word index SHALL be addr_i[log2(DEPTH_WORDS)+1:2]; addr_i[1:0] and upper bits ignored (aliasing wrap-around, no error).
REQ-018 Accepted write SHALL update, at the end of the grant cycle, only the bytes whose be_i bit is 1; be_i=0000 is a legal no-op write.
REQ-019 Accepted read SHALL sample the array in the grant cycle, i.e. before any same-edge write; be_i is ignored for reads.
REQ-020 Every accepted transaction, read or write, SHALL produce exactly one rvalid_o pulse exactly RESP_LATENCY cycles after its grant cycle.
REQ-021 Responses SHALL return in grant order; rvalid_o has no backpressure.
REQ-022 rdata_o SHALL carry the sampled read word for reads and 32'h0 for writes and in idle cycles.
REQ-023 outstanding counter SHALL increment on grant, decrement on rvalid_o, and stay unchanged when both occur in one cycle.
REQ-024 With MAX_OUTSTANDING >= RESP_LATENCY, back-to-back requests SHALL be granted every cycle (full throughput).
REQ-025 With MAX_OUTSTANDING < RESP_LATENCY, gnt_o SHALL drop when the limit is reached and rise again in the cycle the oldest rvalid_o is issued.
REQ-026 A read granted the cycle after a write to the same word SHALL return the written data.
REQ-027 addr_i, we_i, be_i, wdata_i SHALL be ignored in cycles without a grant.
REQ-028 Implementation: RESP_LATENCY-stage shift pipeline of {valid, data} plus outstanding counter; no other state apart from the array.

Reset
REQ-029 While rst_i is high: gnt_o=0, rvalid_o=0, rdata_o=0, outstanding=0, pipeline valid bits cleared.
REQ-030 Transactions in flight when rst_i rises SHALL be discarded with no rvalid_o; writes granted before reset remain in the array.
REQ-031 Array contents SHALL NOT be reset.
REQ-032 First grant is possible in the first cycle after rst_i falls.

Verification
REQ-033 Write 0xA5A5_1234 to 0x100 with be 1111, read 0x100 -> rvalid one cycle after each grant, read returns 0xA5A5_1234.
REQ-034 Write 0xFFFF_FFFF be 1111 then 0x0000_0000 be 0101 to 0x40, read -> 0xFF00_FF00.
REQ-035 RESP_LATENCY=3, MAX_OUTSTANDING=2, req_i held high with 4 reads -> grants in cycles 0,1,3,4; rvalid in cycles 3,4,6,7 in order.
REQ-036 DEPTH_WORDS=1024: write 0x1 to 0x0000_1004, read 0x0000_0004 -> 0x1 (aliasing).
REQ-037 stall_i high 3 cycles with req_i high -> gnt_o low for those cycles, grant on first cycle after stall_i falls.
REQ-038 RESP_LATENCY=2: grant a read, assert rst_i next cycle -> no rvalid_o; outstanding=0 and gnt_o high on first post-reset request.

Source files
------------

// File: rtl/rv32imf_obi_mem_responder.sv
// rv32imf_obi_mem_responder: OBI-style byte-enabled memory with fixed response latency and a limit on outstanding transactions
module rv32imf_obi_mem_responder #(
  parameter int DEPTH_WORDS     = 1024,
  parameter int RESP_LATENCY    = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  input  logic        stall_i
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0]             r_mem [DEPTH_WORDS];
  logic [RESP_LATENCY-1:0] r_v;
  logic [31:0]             r_d [RESP_LATENCY];
  logic [2:0]              r_out;
  logic [AW-1:0]           w_idx;
  logic [2:0]              w_eff;
  logic                    w_unused;
  assign w_idx    = addr_i[AW+1:2];
  assign w_unused = ^{addr_i[31:AW+2], addr_i[1:0]};
  assign rvalid_o = r_v[RESP_LATENCY-1] & ~rst_i;
  assign rdata_o  = rvalid_o ? r_d[RESP_LATENCY-1] : '0;
  assign w_eff    = r_out - {2'b0, rvalid_o};
  assign gnt_o    = req_i & ~stall_i & ~rst_i & (w_eff < 3'(MAX_OUTSTANDING));
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_v   <= '0;
      r_out <= '0;
    end else begin
      r_v[0] <= gnt_o;
      for (int k = 1; k < RESP_LATENCY; k++) r_v[k] <= r_v[k-1];
      r_out <= r_out + {2'b0, gnt_o} - {2'b0, rvalid_o};
    end
  end
  always_ff @(posedge clk_i) begin
    r_d[0] <= we_i ? '0 : r_mem[w_idx];
    for (int k = 1; k < RESP_LATENCY; k++) r_d[k] <= r_d[k-1];
  end
  always_ff @(posedge clk_i) begin
    if (gnt_o && we_i)
      for (int b = 0; b < 4; b++)
        if (be_i[b]) r_mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
  end
endmodule

// File: tb/tb_rv32imf_obi_mem_responder.sv
// tb_rv32imf_obi_mem_responder: directed checks of three responder configurations
module tb_rv32imf_obi_mem_responder;
  logic        clk = 1'b0;
  logic        rst [3];
  logic        req [3];
  logic        we [3];
  logic        stall [3];
  logic        gnt [3];
  logic        rvalid [3];
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic [3:0]  be [3];
  int checks = 0;
  int failures = 0;
  logic        b_req [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
  logic [31:0] b_addr [8] = '{0, 4, 8, 8, 12, 0, 0, 0};
  logic        e_gnt [8] = '{1, 1, 0, 1, 1, 0, 0, 0};
  logic        e_rv [8] = '{0, 0, 0, 1, 1, 0, 1, 1};
  logic [31:0] e_rd [8] = '{0, 0, 0, 32'h11, 32'h22, 0, 32'h33, 32'h44};
  always #5 clk = ~clk;
  rv32imf_obi_mem_responder u0 (
    .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]), .we_i(we[0]),
    .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .stall_i(stall[0]));
  rv32imf_obi_mem_responder #(.RESP_LATENCY(3), .MAX_OUTSTANDING(2)) u1 (
    .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]), .we_i(we[1]),
    .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .stall_i(stall[1]));
  rv32imf_obi_mem_responder #(.RESP_LATENCY(2)) u2 (
    .clk_i(clk), .rst_i(rst[2]), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]), .we_i(we[2]),
    .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .stall_i(stall[2]));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drv(input int d, input logic r, input logic w, input logic [31:0] a,
                     input logic [3:0] b, input logic [31:0] wd);
    req[d] = r;
    we[d] = w;
    addr[d] = a;
    be[d] = b;
    wdata[d] = wd;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1;
      stall[d] = 1'b0;
      drv(d, 1, 0, 0, 4'hF, 0);
    end
    tick();
    tick();
    #3;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_gnt%0d", d), gnt[d], 0);
      chk($sformatf("rst_rvalid%0d", d), rvalid[d], 0);
      chk($sformatf("rst_rdata%0d", d), rdata[d], 0);
    end
    tick();
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b0;
      drv(d, 0, 0, 0, 4'hF, 0);
    end
    drv(0, 1, 1, 32'h100, 4'hF, 32'hA5A5_1234);
    #3;
    chk("first_gnt", gnt[0], 1);
    chk("first_rvalid", rvalid[0], 0);
    tick();
    drv(0, 1, 0, 32'h100, 4'h0, 32'hDEAD_BEEF);
    #3;
    chk("rd_gnt", gnt[0], 1);
    chk("wr_rvalid", rvalid[0], 1);
    chk("wr_rdata", rdata[0], 0);
    tick();
    drv(0, 0, 1, 32'h100, 4'hF, 32'h0);
    #3;
    chk("rd_rvalid", rvalid[0], 1);
    chk("rd_rdata", rdata[0], 32'hA5A5_1234);
    tick();
    drv(0, 1, 1, 32'h40, 4'hF, 32'hFFFF_FFFF);
    #3;
    chk("idle_rvalid", rvalid[0], 0);
    chk("idle_rdata", rdata[0], 0);
    tick();
    drv(0, 1, 1, 32'h40, 4'b0101, 32'h0);
    tick();
    drv(0, 1, 0, 32'h40, 4'h0, 32'h0);
    tick();
    drv(0, 0, 0, 0, 4'h0, 0);
    #3;
    chk("be_rvalid", rvalid[0], 1);
    chk("be_rdata", rdata[0], 32'hFF00_FF00);
    tick();
    drv(0, 1, 1, 32'h1004, 4'hF, 32'h1);
    tick();
    drv(0, 1, 1, 32'h4, 4'h0, 32'hFFFF_FFFF);
    tick();
    drv(0, 1, 0, 32'h7, 4'h0, 0);
    tick();
    drv(0, 0, 0, 0, 4'h0, 0);
    #3;
    chk("alias_rdata", rdata[0], 32'h1);
    tick();
    drv(0, 1, 0, 32'h100, 4'hF, 0);
    stall[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk($sformatf("stall_gnt%0d", i), gnt[0], 0);
      chk($sformatf("stall_rvalid%0d", i), rvalid[0], 0);
      tick();
    end
    stall[0] = 1'b0;
    #3;
    chk("unstall_gnt", gnt[0], 1);
    tick();
    drv(0, 0, 0, 0, 4'h0, 0);
    #3;
    chk("unstall_rdata", rdata[0], 32'hA5A5_1234);
    tick();
    for (int i = 0; i < 4; i++) begin
      drv(1, 1, 1, 32'(i * 4), 4'hF, 32'h11 * 32'(i + 1));
      tick();
      drv(1, 0, 0, 0, 4'h0, 0);
      tick();
      tick();
      tick();
    end
    for (int c = 0; c < 8; c++) begin
      drv(1, b_req[c], 0, b_addr[c], 4'hF, 0);
      #3;
      chk($sformatf("lat3_gnt_c%0d", c), gnt[1], e_gnt[c]);
      chk($sformatf("lat3_rvalid_c%0d", c), rvalid[1], e_rv[c]);
      chk($sformatf("lat3_rdata_c%0d", c), rdata[1], e_rd[c]);
      tick();
    end
    drv(2, 1, 1, 32'h8, 4'hF, 32'hCAFE_F00D);
    tick();
    drv(2, 0, 0, 0, 4'h0, 0);
    tick();
    tick();
    drv(2, 1, 0, 32'h8, 4'h0, 0);
    #3;
    chk("pre_rst_gnt", gnt[2], 1);
    tick();
    rst[2] = 1'b1;
    #3;
    chk("in_rst_gnt", gnt[2], 0);
    chk("in_rst_rvalid", rvalid[2], 0);
    tick();
    rst[2] = 1'b0;
    #3;
    chk("post_rst_gnt", gnt[2], 1);
    chk("discard_rvalid", rvalid[2], 0);
    tick();
    #3;
    chk("post_rst_gnt2", gnt[2], 1);
    chk("post_rst_rvalid", rvalid[2], 0);
    tick();
    drv(2, 0, 0, 0, 4'h0, 0);
    #3;
    chk("keep_rvalid0", rvalid[2], 1);
    chk("keep_rdata0", rdata[2], 32'hCAFE_F00D);
    tick();
    #3;
    chk("keep_rvalid1", rvalid[2], 1);
    chk("keep_rdata1", rdata[2], 32'hCAFE_F00D);
    tick();
    #3;
    chk("end_rvalid", rvalid[2], 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
